// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator behind a 2-entry skid buffer (XLEN 32 or 64).
// Optional SYSTEM/CSR decode is enabled by defining IMM_GEN_PIPE_CSR_EN.
module imm_gen_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
`ifdef IMM_GEN_PIPE_CSR_EN
  localparam logic [2:0] FMT_Z    = 3'd7;
`endif

  typedef struct packed {
    logic            illegal;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
  } ent_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_shamt5;
`ifdef IMM_GEN_PIPE_CSR_EN
  logic [XLEN-1:0] w_zimm;
`endif
  ent_t            w_dec;

  assign w_opcode   = in_inst[6:0];
  assign w_funct3   = in_inst[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  // Sized casts of signed operands sign-extend to XLEN
  assign w_imm_i  = XLEN'($signed(in_inst[31:20]));
  assign w_imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign w_imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign w_imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign w_imm_u  = XLEN'($signed({in_inst[31:12], 12'h000}));
  assign w_shamt  = IS_RV64 ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
  assign w_shamt5 = XLEN'(in_inst[24:20]);
`ifdef IMM_GEN_PIPE_CSR_EN
  assign w_zimm   = XLEN'(in_inst[19:15]);
`endif

  // Opcode decode into a buffer entry
  always_comb begin
    w_dec = '0;
    case (w_opcode)
      7'b0000011, 7'b1100111: begin
        w_dec.fmt = FMT_I;
        w_dec.imm = w_imm_i;
      end
      7'b0010011: begin
        if (w_is_shift) begin
          w_dec.fmt = FMT_SH;
          w_dec.imm = w_shamt;
        end else begin
          w_dec.fmt = FMT_I;
          w_dec.imm = w_imm_i;
        end
      end
      7'b0011011: begin
        if (!IS_RV64) begin
          w_dec.illegal = 1'b1;
        end else if (w_is_shift) begin
          w_dec.fmt = FMT_SH;
          w_dec.imm = w_shamt5;
        end else begin
          w_dec.fmt = FMT_I;
          w_dec.imm = w_imm_i;
        end
      end
      7'b0100011: begin
        w_dec.fmt = FMT_S;
        w_dec.imm = w_imm_s;
      end
      7'b1100011: begin
        w_dec.fmt = FMT_B;
        w_dec.imm = w_imm_b;
      end
      7'b1101111: begin
        w_dec.fmt = FMT_J;
        w_dec.imm = w_imm_j;
      end
      7'b0110111, 7'b0010111: begin
        w_dec.fmt = FMT_U;
        w_dec.imm = w_imm_u;
      end
      7'b0110011: w_dec.fmt = FMT_NONE;
      7'b0111011: w_dec.illegal = !IS_RV64;
`ifdef IMM_GEN_PIPE_CSR_EN
      7'b1110011: begin
        case (w_funct3)
          3'b101, 3'b110, 3'b111: begin
            w_dec.fmt = FMT_Z;
            w_dec.imm = w_zimm;
          end
          3'b001, 3'b010, 3'b011: begin
            w_dec.fmt = FMT_I;
            w_dec.imm = w_imm_i;
          end
          3'b000:  w_dec.fmt = FMT_NONE;
          default: w_dec.illegal = 1'b1;
        endcase
      end
`endif
      default: w_dec.illegal = 1'b1;
    endcase
  end

  logic [1:0]           r_count;
  logic                 r_in_ready;
  logic                 r_out_valid;
  ent_t                 r_head;
  ent_t                 r_tail;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [1:0] w_count_nxt;
  ent_t       w_head_nxt;
  ent_t       w_tail_nxt;
  logic       w_push;
  logic       w_pop;
  logic       w_err_inc;

  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = r_out_valid && out_ready;
  assign w_err_inc = w_push && w_dec.illegal && !(&r_err_cnt);

  // Buffer next state; head is zeroed whenever the buffer becomes empty
  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    if (flush) begin
      w_count_nxt = 2'd0;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            w_head_nxt  = w_dec;
            w_count_nxt = 2'd1;
          end
        end
        2'd1: begin
          case ({w_push, w_pop})
            2'b11: w_head_nxt = w_dec;
            2'b10: begin
              w_tail_nxt  = w_dec;
              w_count_nxt = 2'd2;
            end
            2'b01: begin
              w_head_nxt  = '0;
              w_count_nxt = 2'd0;
            end
            default: w_count_nxt = r_count;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            w_head_nxt  = r_tail;
            w_tail_nxt  = '0;
            w_count_nxt = 2'd1;
          end
        end
        default: begin
          w_count_nxt = 2'd0;
          w_head_nxt  = '0;
          w_tail_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      if (w_err_inc) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_head.imm;
  assign out_fmt     = r_head.fmt;
  assign out_illegal = r_head.illegal;
  assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 and RV64 instances share stimulus and a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  err32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  err64;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] qw[$];
  int          m_err32 = 0;
  int          m_err64 = 0;

  imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .out_valid(out_valid32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32), .err_count(err32));

  imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .out_valid(out_valid64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64), .err_count(err64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sext(input longint v, input int bits);
    longint r;
    r = v;
    if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
    return r;
  endfunction

  // Reference decode written directly from the instruction-format rules
  task automatic ref_decode(input logic [31:0] inst, input bit rv64,
                            output logic [63:0] imm, output logic [2:0] fmt, output bit ill);
    logic [2:0] f3;
    f3 = inst[14:12];
    imm = 64'd0; fmt = 3'd0; ill = 1'b0;
    case (inst[6:0])
      7'h03, 7'h67: begin fmt = 3'd1; imm = sext(longint'(inst[31:20]), 12); end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = 3'd6;
          imm = rv64 ? 64'(inst[25:20]) : 64'(inst[24:20]);
        end else begin
          fmt = 3'd1; imm = sext(longint'(inst[31:20]), 12);
        end
      end
      7'h1B: begin
        if (!rv64) ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin fmt = 3'd6; imm = 64'(inst[24:20]); end
        else begin fmt = 3'd1; imm = sext(longint'(inst[31:20]), 12); end
      end
      7'h23: begin
        fmt = 3'd2;
        imm = sext(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
      end
      7'h63: begin
        fmt = 3'd3;
        imm = sext(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                   longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      end
      7'h6F: begin
        fmt = 3'd5;
        imm = sext(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096 +
                   longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
      end
      7'h37, 7'h17: begin fmt = 3'd4; imm = sext(longint'(inst[31:12]) * 4096, 32); end
      7'h33: ill = 1'b0;
      7'h3B: ill = !rv64;
`ifdef IMM_GEN_PIPE_CSR_EN
      7'h73: begin
        if (f3 >= 3'd5) begin fmt = 3'd7; imm = 64'(inst[19:15]); end
        else if (f3 >= 3'd1 && f3 <= 3'd3) begin fmt = 3'd1; imm = sext(longint'(inst[31:20]), 12); end
        else if (f3 == 3'd4) ill = 1'b1;
      end
`endif
      default: ill = 1'b1;
    endcase
  endtask

  // Drive one cycle of stimulus and advance the reference model across the edge
  task automatic step(input bit v, input logic [31:0] inst, input bit rdy, input bit fl);
    bit push, pop, i32, i64;
    logic [63:0] dimm;
    logic [2:0]  dfmt;
    in_valid = v; in_inst = inst; out_ready = rdy; flush = fl;
    push = v && (qw.size() != 2);
    pop  = (qw.size() != 0) && rdy;
    ref_decode(inst, 1'b0, dimm, dfmt, i32);
    ref_decode(inst, 1'b1, dimm, dfmt, i64);
    if (push && i32 && m_err32 < 255) m_err32++;
    if (push && i64 && m_err64 < 255) m_err64++;
    @(posedge clk);
    #1;
    if (fl) qw.delete();
    else begin
      if (pop) void'(qw.pop_front());
      if (push) qw.push_back(inst);
    end
  endtask

  task automatic model_reset();
    qw.delete();
    m_err32 = 0;
    m_err64 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'd0 || fmt32 !== 3'd0 ||
        ill32 !== 1'b0 || err32 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset32: v=%b r=%b imm=%h fmt=%0d ill=%b err=%0d, required v=0 r=1 rest 0",
               out_valid32, in_ready32, imm32, fmt32, ill32, err32);
    end
    n_tests++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || imm64 !== 64'd0 || fmt64 !== 3'd0 ||
        ill64 !== 1'b0 || err64 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset64: v=%b r=%b imm=%h fmt=%0d ill=%b err=%0d, required v=0 r=1 rest 0",
               out_valid64, in_ready64, imm64, fmt64, ill64, err64);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    n_tests++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || fmt32 !== 3'd1 || ill32 !== 1'b0) begin
      n_fail++;
      $display("FAIL addi32: v=%b imm=%h fmt=%0d ill=%b, required 1 ffffffff 1 0",
               out_valid32, imm32, fmt32, ill32);
    end
    n_tests++;
    if (imm64 !== 64'hFFFFFFFFFFFFFFFF || fmt64 !== 3'd1) begin
      n_fail++;
      $display("FAIL addi64: imm=%h fmt=%0d, required ffffffffffffffff 1", imm64, fmt64);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid32 !== 1'b0 || imm32 !== 32'd0 || fmt32 !== 3'd0 || in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: v=%b imm=%h fmt=%0d r=%b, required 0 0 0 1",
               out_valid32, imm32, fmt32, in_ready32);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'hFE21AE23, 1'b1, 1'b0);
    n_tests++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFFFFFC || fmt32 !== 3'd2) begin
      n_fail++;
      $display("FAIL b2b_sw: v=%b imm=%h fmt=%0d, required 1 fffffffc 2", out_valid32, imm32, fmt32);
    end
    step(1'b1, 32'h123452B7, 1'b1, 1'b0);
    n_tests++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'h12345000 || fmt32 !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_lui: v=%b imm=%h fmt=%0d, required 1 12345000 4", out_valid32, imm32, fmt32);
    end
    n_tests++;
    if (imm64 !== 64'h0000000012345000 || fmt64 !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_lui64: imm=%h fmt=%0d, required 0000000012345000 4", imm64, fmt64);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_shift();
    step(1'b1, 32'h4070D093, 1'b1, 1'b0);
    n_tests++;
    if (imm32 !== 32'd7 || fmt32 !== 3'd6 || imm64 !== 64'd7 || fmt64 !== 3'd6) begin
      n_fail++;
      $display("FAIL srai: imm32=%0d fmt32=%0d imm64=%0d fmt64=%0d, required 7 6 7 6",
               imm32, fmt32, imm64, fmt64);
    end
    step(1'b1, 32'h4270D093, 1'b1, 1'b0);
    n_tests++;
    if (imm32 !== 32'd7 || imm64 !== 64'd39 || fmt64 !== 3'd6) begin
      n_fail++;
      $display("FAIL srai_shamt6: imm32=%0d imm64=%0d fmt64=%0d, required 7 39 6", imm32, imm64, fmt64);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] w1, w2, w3;
    w1 = (32'd1 << 20) | 32'h93;
    w2 = (32'd2 << 20) | 32'h93;
    w3 = (32'd3 << 20) | 32'h93;
    step(1'b1, w1, 1'b0, 1'b0);
    n_tests++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b1 || imm32 !== 32'd1) begin
      n_fail++;
      $display("FAIL bp_first: r=%b v=%b imm=%0d, required 1 1 1", in_ready32, out_valid32, imm32);
    end
    step(1'b1, w2, 1'b0, 1'b0);
    n_tests++;
    if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0 || imm32 !== 32'd1) begin
      n_fail++;
      $display("FAIL bp_full: r32=%b r64=%b imm=%0d, required 0 0 1", in_ready32, in_ready64, imm32);
    end
    step(1'b1, w3, 1'b0, 1'b0);
    n_tests++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || imm32 !== 32'd1 || fmt32 !== 3'd1) begin
      n_fail++;
      $display("FAIL bp_hold: r=%b v=%b imm=%0d fmt=%0d, required 0 1 1 1",
               in_ready32, out_valid32, imm32, fmt32);
    end
    step(1'b1, w3, 1'b1, 1'b0);
    n_tests++;
    if (in_ready32 !== 1'b1 || imm32 !== 32'd2) begin
      n_fail++;
      $display("FAIL bp_pop1: r=%b imm=%0d, required 1 2", in_ready32, imm32);
    end
    step(1'b1, w3, 1'b1, 1'b0);
    n_tests++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'd3) begin
      n_fail++;
      $display("FAIL bp_third: v=%b imm=%0d, required 1 3", out_valid32, imm32);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: v=%b, required 0", out_valid32);
    end
  endtask

  task automatic test_flush_push();
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
    n_tests++;
    if (out_valid32 !== 1'b0 || err32 !== 8'd1 || err64 !== 8'd1) begin
      n_fail++;
      $display("FAIL flush_push: v=%b err32=%0d err64=%0d, required 0 1 1", out_valid32, err32, err64);
    end
    step(1'b1, (32'd5 << 20) | 32'h93, 1'b0, 1'b0);
    step(1'b1, (32'd6 << 20) | 32'h93, 1'b1, 1'b1);
    n_tests++;
    if (out_valid32 !== 1'b0 || imm32 !== 32'd0 || in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_one: v=%b imm=%0d r=%b, required 0 0 1", out_valid32, imm32, in_ready32);
    end
  endtask

  task automatic test_csr();
    int e;
    e = m_err32;
    step(1'b1, 32'h7C1FD073, 1'b1, 1'b0);
    n_tests++;
`ifdef IMM_GEN_PIPE_CSR_EN
    if (fmt32 !== 3'd7 || imm32 !== 32'h1F || ill32 !== 1'b0 || err32 !== 8'(e)) begin
      n_fail++;
      $display("FAIL csrrwi: fmt=%0d imm=%h ill=%b err=%0d, required 7 1f 0 %0d", fmt32, imm32, ill32, err32, e);
    end
`else
    if (ill32 !== 1'b1 || imm32 !== 32'd0 || fmt32 !== 3'd0 || err32 !== 8'(e + 1)) begin
      n_fail++;
      $display("FAIL csrrwi_off: ill=%b imm=%h fmt=%0d err=%0d, required 1 0 0 %0d", ill32, imm32, fmt32, err32, e + 1);
    end
`endif
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal_sat();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
      n_tests++;
      if (out_valid32 !== 1'b1 || ill32 !== 1'b1 || imm32 !== 32'd0 || fmt32 !== 3'd0 || ill64 !== 1'b1) begin
        n_fail++;
        bad++;
        if (bad <= 4)
          $display("FAIL illegal_out[%0d]: v=%b ill=%b imm=%h fmt=%0d, required 1 1 0 0",
                   i, out_valid32, ill32, imm32, fmt32);
      end
    end
    n_tests++;
    if (err32 !== 8'd255 || err64 !== 8'd255) begin
      n_fail++;
      $display("FAIL err_sat: err32=%0d err64=%0d, required 255 255", err32, err64);
    end
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    n_tests++;
    if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_flush_full: v=%b r=%b, required 1 0", out_valid32, in_ready32);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1);
    n_tests++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || ill32 !== 1'b0 || err32 !== 8'd255) begin
      n_fail++;
      $display("FAIL flush_full: v=%b r=%b ill=%b err=%0d, required 0 1 0 255",
               out_valid32, in_ready32, ill32, err32);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, (32'd9 << 20) | 32'h93, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'd0 || err32 !== 8'd0 ||
        out_valid64 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b r=%b imm=%h err=%0d, required 0 1 0 0",
               out_valid32, in_ready32, imm32, err32);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0]  ops[13];
    logic [31:0] r, inst;
    logic [63:0] e32i, e64i;
    logic [2:0]  e32f, e64f;
    bit          e32l, e64l;
    int          bad;
    ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h73, 7'h7F};
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      e32i = 64'd0; e64i = 64'd0; e32f = 3'd0; e64f = 3'd0; e32l = 1'b0; e64l = 1'b0;
      if (qw.size() != 0) begin
        ref_decode(qw[0], 1'b0, e32i, e32f, e32l);
        ref_decode(qw[0], 1'b1, e64i, e64f, e64l);
      end
      n_tests++;
      if (out_valid32 !== (qw.size() != 0) || in_ready32 !== (qw.size() != 2) ||
          out_valid64 !== (qw.size() != 0) || in_ready64 !== (qw.size() != 2)) begin
        n_fail++; bad++;
        if (bad <= 8) $display("FAIL rnd_hs[%0d]: v=%b r=%b, required count %0d", c, out_valid32, in_ready32, qw.size());
      end
      n_tests++;
      if (imm32 !== e32i[31:0] || fmt32 !== e32f || ill32 !== e32l) begin
        n_fail++; bad++;
        if (bad <= 8) $display("FAIL rnd32[%0d]: imm=%h fmt=%0d ill=%b, required %h %0d %b",
                               c, imm32, fmt32, ill32, e32i[31:0], e32f, e32l);
      end
      n_tests++;
      if (imm64 !== e64i || fmt64 !== e64f || ill64 !== e64l) begin
        n_fail++; bad++;
        if (bad <= 8) $display("FAIL rnd64[%0d]: imm=%h fmt=%0d ill=%b, required %h %0d %b",
                               c, imm64, fmt64, ill64, e64i, e64f, e64l);
      end
      n_tests++;
      if (err32 !== 8'(m_err32) || err64 !== 8'(m_err64)) begin
        n_fail++; bad++;
        if (bad <= 8) $display("FAIL rnd_err[%0d]: err32=%0d err64=%0d, required %0d %0d",
                               c, err32, err64, m_err32, m_err64);
      end
      r = $urandom();
      inst = {r[31:7], ops[$urandom_range(0, 12)]};
      step($urandom_range(0, 3) != 0, inst, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_shift();
    test_backpressure();
    test_flush_push();
    test_csr();
    test_illegal_sat();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
